tank_vga_timing: RTL and testbench
==================================

TANK_VGA_TIMING -- requirements
Module: tank_vga_timing

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front-porch pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync pixels.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back-porch pixels (line total 800).
REQ-005 SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front-porch lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back-porch lines (frame total 525).
REQ-009 SHALL have parameter PIPE_DELAY, default 2, cycles of delay on the *_pipe outputs; legal range 0..4.
REQ-010 SHALL have port vga_clk, input, 1, pixel clock (25 MHz nominal); the block's only clock.
REQ-011 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-012 SHALL have port DrawX, output, 10, current horizontal count.
REQ-013 SHALL have port DrawY, output, 10, current vertical count.
REQ-014 SHALL have port blank, output, 1, high when the current pixel is visible (display enable).
REQ-015 SHALL have port hs, output, 1, active-low horizontal sync aligned with DrawX/DrawY.
REQ-016 SHALL have port vs, output, 1, active-low vertical sync aligned with DrawX/DrawY.
REQ-017 SHALL have port hs_pipe, output, 1, hs delayed by PIPE_DELAY cycles.
REQ-018 SHALL have port vs_pipe, output, 1, vs delayed by PIPE_DELAY cycles.
REQ-019 SHALL have port blank_pipe, output, 1, blank delayed by PIPE_DELAY cycles, matched to downstream ROM+palette+register latency.
REQ-020 SHALL have port frame_start, output, 1, one-cycle pulse at pixel (0,0) of each frame.
REQ-021 SHALL have port line_start, output, 1, one-cycle pulse at DrawX==0 of every line.
REQ-022 SHALL have port frame_count, output, 16, completed-frame counter.

Function
REQ-023 SHALL register every output on the rising edge of vga_clk; no combinational input-to-output path.
REQ-024 SHALL increment DrawX by 1 per cycle, wrapping from H_TOTAL-1 (799) to 0.
REQ-025 SHALL increment DrawY by 1 on each DrawX wrap, wrapping from V_TOTAL-1 (524) to 0; DrawY unchanged otherwise.
REQ-026 SHALL drive blank=1 iff DrawX<H_VISIBLE and DrawY<V_VISIBLE, in the same cycle as the corresponding DrawX/DrawY (decode from next-state counters).
REQ-027 SHALL drive hs=0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751), else 1, same-cycle aligned.
REQ-028 SHALL drive vs=0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491) for the whole of those lines, else 1.
REQ-029 SHALL implement *_pipe outputs as a PIPE_DELAY-deep shift register per signal; PIPE_DELAY=0 makes *_pipe equal the undelayed outputs.
REQ-030 SHALL assert line_start when DrawX==0, except while reset is high and except the reset-held (0,0) state.
REQ-031 SHALL assert frame_start when DrawX==0 and DrawY==0 reached by wrap from (799,524); never from the reset-held state.
REQ-032 SHALL increment frame_count by 1 on the same edge frame_start rises; wraps 65535 -> 0.
REQ-033 SHALL treat counters as unsigned; DrawX/DrawY never exceed 799/524.

Reset
REQ-034 SHALL, on any edge with reset=1, set DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=0, line_start=0, frame_count=0.
REQ-035 SHALL, on reset, flush all pipeline stages so hs_pipe=1, vs_pipe=1, blank_pipe=0 until valid data propagates through PIPE_DELAY stages.
REQ-036 SHALL, on the first edge with reset=0, advance DrawX 0->1; reset asserted mid-frame returns to (0,0) on the next edge with no frame_count increment.

Verification
REQ-037 Release reset, run 800 cycles -> DrawX 0..799 then 0, DrawY 0->1 exactly at the wrap, line_start pulses once at the wrap.
REQ-038 Run one full line -> blank high for DrawX 0..639, hs low for DrawX 656..751 only (96 cycles), vs=1 throughout.
REQ-039 Run 420000 cycles after reset -> vs low for exactly 1600 cycles (DrawY 490..491), first frame_start at cycle 420000 with frame_count 0->1.
REQ-040 PIPE_DELAY=2: compare blank_pipe/hs_pipe/vs_pipe against blank/hs/vs -> identical sequence shifted by exactly 2 cycles; first 2 post-reset cycles blank_pipe=0.
REQ-041 Assert reset for 1 cycle at DrawX=300, DrawY=200 -> next edge DrawX=0, DrawY=0, hs=vs=1, frame_count=0, no frame_start.
REQ-042 Force frame_count to 65535 via long run or backdoor, complete a frame -> frame_count=0.

Source files
------------

// File: rtl/tank_vga_timing.sv
// VGA raster timing generator: pixel/line counters, sync and blank decode,
// frame/line markers, and delayed sync/blank copies for the pixel pipeline.
module tank_vga_timing #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        hs_pipe,
    output logic        vs_pipe,
    output logic        blank_pipe,
    output logic        frame_start,
    output logic        line_start,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] next_x;
    logic [9:0] next_y;
    logic       x_wrap;
    logic       frame_wrap;

    always_comb begin
        x_wrap     = (DrawX == H_LAST);
        frame_wrap = x_wrap && (DrawY == V_LAST);
        next_x     = x_wrap ? '0 : DrawX + 10'd1;
        next_y     = DrawY;
        if (x_wrap) begin
            next_y = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
        end
    end

    // Decode from the next-state counters so the registered flags line up
    // with the registered DrawX/DrawY they describe.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b1;
            hs          <= 1'b1;
            vs          <= 1'b1;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            frame_count <= '0;
        end else begin
            DrawX       <= next_x;
            DrawY       <= next_y;
            blank       <= (next_x < H_VIS) && (next_y < V_VIS);
            hs          <= !((next_x >= HS_START) && (next_x < HS_END));
            vs          <= !((next_y >= VS_START) && (next_y < VS_END));
            line_start  <= x_wrap;
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    generate
        if (PIPE_DELAY == 0) begin : g_no_pipe
            assign hs_pipe    = hs;
            assign vs_pipe    = vs;
            assign blank_pipe = blank;
        end else begin : g_pipe
            logic [PIPE_DELAY-1:0] hs_sr;
            logic [PIPE_DELAY-1:0] vs_sr;
            logic [PIPE_DELAY-1:0] blank_sr;
            logic [PIPE_DELAY:0]   hs_cat;
            logic [PIPE_DELAY:0]   vs_cat;
            logic [PIPE_DELAY:0]   blank_cat;

            // Append the live value below the stages; dropping the top bit
            // shifts by one and works for a single-stage pipe too.
            assign hs_cat    = {hs_sr, hs};
            assign vs_cat    = {vs_sr, vs};
            assign blank_cat = {blank_sr, blank};

            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    hs_sr    <= '1;
                    vs_sr    <= '1;
                    blank_sr <= '0;
                end else begin
                    hs_sr    <= hs_cat[PIPE_DELAY-1:0];
                    vs_sr    <= vs_cat[PIPE_DELAY-1:0];
                    blank_sr <= blank_cat[PIPE_DELAY-1:0];
                end
            end

            assign hs_pipe    = hs_sr[PIPE_DELAY-1];
            assign vs_pipe    = vs_sr[PIPE_DELAY-1];
            assign blank_pipe = blank_sr[PIPE_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_tank_vga_timing.sv
// Scoreboard bench: a default-timing instance and a tiny-raster instance are
// driven with random resets and checked against a time-since-reset model.
module tb_tank_vga_timing;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        hsp;
        logic        vsp;
        logic        bp;
        logic        fs;
        logic        ls;
        logic [15:0] fc;
    } out_t;

    localparam int unsigned NCYC = 16000;

    logic vga_clk = 1'b0;
    logic rst0, rst1;
    logic [9:0]  x0, y0, x1, y1;
    logic        b0, h0, v0, hp0, vp0, bp0, fs0, ls0;
    logic        b1, h1, v1, hp1, vp1, bp1, fs1, ls1;
    logic [15:0] fc0, fc1;

    always #5 vga_clk = ~vga_clk;

    tank_vga_timing dut0 (
        .vga_clk(vga_clk), .reset(rst0), .DrawX(x0), .DrawY(y0),
        .blank(b0), .hs(h0), .vs(v0), .hs_pipe(hp0), .vs_pipe(vp0),
        .blank_pipe(bp0), .frame_start(fs0), .line_start(ls0),
        .frame_count(fc0)
    );

    tank_vga_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .PIPE_DELAY(3)
    ) dut1 (
        .vga_clk(vga_clk), .reset(rst1), .DrawX(x1), .DrawY(y1),
        .blank(b1), .hs(h1), .vs(v1), .hs_pipe(hp1), .vs_pipe(vp1),
        .blank_pipe(bp1), .frame_start(fs1), .line_start(ls1),
        .frame_count(fc1)
    );

    out_t sb0[$];
    out_t sb1[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Expected undelayed outputs purely from cycles elapsed since reset.
    function automatic out_t calc(input int k, input int unsigned t);
        int unsigned hv, hf, hsy, hb, vv, vf, vsy, vb, ht, vt, x, y;
        out_t o;
        if (k == 0) begin
            hv = 640; hf = 16; hsy = 96; hb = 48; vv = 480; vf = 10; vsy = 2; vb = 33;
        end else begin
            hv = 8; hf = 2; hsy = 3; hb = 3; vv = 6; vf = 2; vsy = 2; vb = 2;
        end
        ht = hv + hf + hsy + hb;
        vt = vv + vf + vsy + vb;
        x  = t % ht;
        y  = (t / ht) % vt;
        o       = '0;
        o.x     = 10'(x);
        o.y     = 10'(y);
        o.blank = (x < hv) && (y < vv);
        o.hs    = !((x >= hv + hf) && (x < hv + hf + hsy));
        o.vs    = !((y >= vv + vf) && (y < vv + vf + vsy));
        o.ls    = (t != 0) && (x == 0);
        o.fs    = (t != 0) && (x == 0) && (y == 0);
        o.fc    = 16'(t / (ht * vt));
        return o;
    endfunction

    task automatic check(input string name, input int n, input out_t got, input out_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got x=%0d y=%0d b=%b hs=%b vs=%b hp=%b vp=%b bp=%b fs=%b ls=%b fc=%0d | exp x=%0d y=%0d b=%b hs=%b vs=%b hp=%b vp=%b bp=%b fs=%b ls=%b fc=%0d",
                     name, n, got.x, got.y, got.blank, got.hs, got.vs, got.hsp, got.vsp, got.bp, got.fs, got.ls, got.fc,
                     exp.x, exp.y, exp.blank, exp.hs, exp.vs, exp.hsp, exp.vsp, exp.bp, exp.fs, exp.ls, exp.fc);
        end
    endtask

    // Monitor: every edge presents a new output word, compared on the negedge.
    int mon_n = 0;
    initial begin
        out_t g, e;
        forever begin
            @(negedge vga_clk);
            mon_n++;
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
                g = '{x0, y0, b0, h0, v0, hp0, vp0, bp0, fs0, ls0, fc0};
                check("default", mon_n, g, e);
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                g = '{x1, y1, b1, h1, v1, hp1, vp1, bp1, fs1, ls1, fc1};
                check("small", mon_n, g, e);
            end
        end
    end

    // Driver and reference model.
    initial begin
        int unsigned t[2];
        logic [2:0]  hist[2][4];
        int unsigned dly[2];
        logic        r[2];
        out_t        e[2];
        logic [2:0]  u, p;
        dly[0] = 2;
        dly[1] = 3;
        t[0] = 0;
        t[1] = 0;
        for (int n = 0; n < int'(NCYC); n++) begin
            if (n < 3) begin
                r[0] = 1'b1;
                r[1] = 1'b1;
            end else begin
                // Line 3, pixel 300 gets a one-cycle mid-line reset.
                r[0] = (n == 3 + 3 * 800 + 299) || ($urandom_range(0, 4999) == 0);
                r[1] = ($urandom_range(0, 699) == 0);
            end
            rst0 = r[0];
            rst1 = r[1];
            for (int k = 0; k < 2; k++) begin
                t[k] = r[k] ? 0 : t[k] + 1;
                e[k] = calc(k, t[k]);
                u = {e[k].blank, e[k].hs, e[k].vs};
                if (r[k]) begin
                    for (int i = 0; i < 4; i++) hist[k][i] = 3'b011;
                    p = 3'b011;
                end else begin
                    p = hist[k][dly[k] - 1];
                end
                for (int i = 3; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = u;
                e[k].bp  = p[2];
                e[k].hsp = p[1];
                e[k].vsp = p[0];
            end
            @(posedge vga_clk);
            sb0.push_back(e[0]);
            sb1.push_back(e[1]);
            #2;
        end
        @(negedge vga_clk);
        #1;
        n_cmp++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d/%0d pending, exp 0/0", sb0.size(), sb1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
